// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence detector slice.
// Holds the serializer FSM encoding and the idle line level.
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_ser_state_t;

  localparam logic SEQ_IDLE_BIT = 1'b0;

  function automatic int unsigned seq_cnt_w(
    input int unsigned width
  );
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_word_buffer.sv
// One-word hold slot in front of the serializer shifter.
// A slot freed by a load can be refilled on the same edge.
module seq_word_buffer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             load,
  output logic             in_ready,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid
);

  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;
  logic             hold_valid_q;
  logic             hold_valid_d;
  logic             accept;

  assign in_ready   = !hold_valid_q || load;
  assign accept     = in_valid && in_ready;
  assign hold_data  = hold_q;
  assign hold_valid = hold_valid_q;

  // Next slot contents: a refill wins over the load that empties it.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end else if (load) begin
      hold_valid_d = 1'b0;
    end
  end

  // Slot registers; reset discards any held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the Moore sequence detectors.
// Words stream back to back through a one-word hold buffer.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = SEQ_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             inp,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CW = seq_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_ser_state_t   state_q;
  seq_ser_state_t   state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;
  logic             inp_q;
  logic             inp_d;
  logic             bit_valid_q;
  logic             bit_valid_d;
  logic             last_bit_q;
  logic             last_bit_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             load;

  function automatic logic head_of(
    input logic [WIDTH-1:0] v
  );
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(
    input logic [WIDTH-1:0] v
  );
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign load = hold_valid
             && (state_q == IDLE || last_bit_q);

  seq_word_buffer #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .load       (load),
    .in_ready   (in_ready),
    .hold_data  (hold_data),
    .hold_valid (hold_valid)
  );

  // Shifter, counter and FSM next state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      shift_d   = hold_data;
      bit_cnt_d = '0;
      state_d   = SHIFT;
    end else if (state_q == SHIFT) begin
      if (bit_cnt_q == LAST) begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end else begin
        shift_d   = adv(shift_q);
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  // Registered serial outputs track the next shifter head.
  always_comb begin
    inp_d       = IDLE_BIT;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    if (state_d == SHIFT) begin
      inp_d       = head_of(shift_d);
      bit_valid_d = 1'b1;
      last_bit_d  = (bit_cnt_d == LAST);
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      inp_q       <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      inp_q       <= inp_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
    end
  end

  assign inp       = inp_q;
  assign bit_valid = bit_valid_q;
  assign last_bit  = last_bit_q;
  assign busy      = (state_q == SHIFT) || hold_valid;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer.
// Three instances: W8 MSB-first, W7 MSB-first, W8 LSB-first.
module tb_seq_bit_serializer;

  logic       clk;
  logic       reset;

  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       inp0, inp1, inp2;
  logic       bv0, bv1, bv2;
  logic       lb0, lb1, lb2;
  logic       busy0, busy1, busy2;

  int total;
  int bad;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  int         run[3];
  int         lastrun[3];

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) u_d0 (
    .clk(clk), .reset(reset),
    .in_data(data0), .in_valid(v0), .in_ready(r0),
    .inp(inp0), .bit_valid(bv0), .last_bit(lb0),
    .busy(busy0)
  );

  seq_bit_serializer #(
    .WIDTH(7), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) u_d1 (
    .clk(clk), .reset(reset),
    .in_data(data1), .in_valid(v1), .in_ready(r1),
    .inp(inp1), .bit_valid(bv1), .last_bit(lb1),
    .busy(busy1)
  );

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) u_d2 (
    .clk(clk), .reset(reset),
    .in_data(data2), .in_valid(v2), .in_ready(r2),
    .inp(inp2), .bit_valid(bv2), .last_bit(lb2),
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(
    input int d, input logic v, input logic [7:0] w
  );
    case (d)
      0: begin v0 = v; data0 = w; end
      1: begin v1 = v; data1 = w[6:0]; end
      default: begin v2 = v; data2 = w; end
    endcase
  endtask

  function automatic logic rdy_of(input int d);
    case (d)
      0: return r0;
      1: return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0: return busy0 | bv0;
      1: return busy1 | bv1;
      default: return busy2 | bv2;
    endcase
  endfunction

  // e holds the expected bits in output order, first bit at e[n-1].
  task automatic push(
    input int d, input logic [7:0] e, input int n
  );
    for (int i = n - 1; i >= 0; i--) begin
      logic [1:0] x;
      x = {e[i], (i == 0)};
      case (d)
        0: q0.push_back(x);
        1: q1.push_back(x);
        default: q2.push_back(x);
      endcase
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(
    input int d, input logic [7:0] w,
    input logic [7:0] e, input int n,
    output int waits
  );
    logic rdy;
    bit   done;
    waits = 0;
    done  = 0;
    set_in(d, 1'b1, w);
    while (!done) begin
      @(negedge clk);
      rdy = rdy_of(d);
      @(posedge clk);
      #1;
      if (rdy) begin
        push(d, e, n);
        done = 1;
      end else begin
        waits++;
        if (waits > 100) begin
          total++;
          bad++;
          $display("FAIL send_timeout d%0d: ready=0 want 1", d);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle(input int d);
    set_in(d, 1'b0, 8'h00);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy_of(d) && t < 200);
    if (busy_of(d)) begin
      total++;
      bad++;
      $display("FAIL drain_timeout d%0d: busy=1 want 0", d);
    end
    cyc(1);
  endtask

  task automatic mon(
    input int d, input logic bv,
    input logic ib, input logic lb
  );
    logic [1:0] e;
    int         sz;
    if (bv) begin
      case (d)
        0: sz = q0.size();
        1: sz = q1.size();
        default: sz = q2.size();
      endcase
      total++;
      if (sz == 0) begin
        bad++;
        $display("FAIL extra_bit d%0d: got inp=%0b want none",
                 d, ib);
      end else begin
        case (d)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        if ({ib, lb} !== e) begin
          bad++;
          $display("FAIL bit d%0d: got inp/last=%b%b want %b%b",
                   d, ib, lb, e[1], e[0]);
        end
      end
      run[d]++;
    end else begin
      if (run[d] != 0) lastrun[d] = run[d];
      run[d] = 0;
    end
  endtask

  initial begin
    int w1, w2, w3;
    int seen, t;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      run[i]     = 0;
      lastrun[i] = 0;
    end
    reset = 1'b0;
    v0 = 0; v1 = 0; v2 = 0;
    data0 = '0; data1 = '0; data2 = '0;

    fork
      forever begin
        @(negedge clk);
        mon(0, bv0, inp0, lb0);
        mon(1, bv1, inp1, lb1);
        mon(2, bv2, inp2, lb2);
      end
    join_none

    // Reset for 2 cycles, then release.
    cyc(2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_inp_w7", inp1, 0);
    check("rst_bv_w7", bv1, 0);
    check("rst_rdy_w7", r1, 1);
    check("rst_busy_w7", busy1, 0);
    check("rst_lb_w7", lb1, 0);
    check("rst_inp_w8", inp0, 0);
    check("rst_rdy_w8", r0, 1);
    cyc(1);

    // Single 7-bit word, latency check.
    send(1, 8'b0001_0011, 8'b0001_0011, 7, w1);
    idle(1);
    @(negedge clk);
    check("lat_bv_pre", bv1, 0);
    check("lat_busy_pre", busy1, 1);
    @(negedge clk);
    check("lat_bv_first", bv1, 1);
    drain(1);
    check("single_run", lastrun[1], 7);

    // Back-to-back A5, 3C with valid held.
    send(0, 8'hA5, 8'hA5, 8, w1);
    send(0, 8'h3C, 8'h3C, 8, w2);
    idle(0);
    check("b2b_w2_imm", w2, 0);
    @(negedge clk);
    check("b2b_full_rdy", r0, 0);
    check("b2b_full_busy", busy0, 1);
    t = 0;
    while (!lb0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b_last_seen", lb0, 1);
    check("b2b_load_rdy", r0, 1);
    cyc(1);
    drain(0);
    check("b2b_run", lastrun[0], 16);

    // LSB-first.
    send(2, 8'h01, 8'b1000_0000, 8, w1);
    idle(2);
    drain(2);
    check("lsb_run", lastrun[2], 8);

    // Backpressure: three words queued.
    send(0, 8'h96, 8'h96, 8, w1);
    send(0, 8'h0F, 8'h0F, 8, w2);
    send(0, 8'hC3, 8'hC3, 8, w3);
    idle(0);
    check("bp_w1", w1, 0);
    check("bp_w2", w2, 0);
    check("bp_w3", w3, 7);
    drain(0);
    check("bp_run", lastrun[0], 24);

    // Mid-word reset with a second word held.
    send(0, 8'hFF, 8'hFF, 8, w1);
    send(0, 8'h55, 8'h55, 8, w2);
    idle(0);
    seen = 0;
    t = 0;
    while (seen < 4 && t < 30) begin
      @(negedge clk);
      if (bv0) seen++;
      t++;
    end
    check("mr_bits_seen", seen, 4);
    #1;
    reset = 1'b0;
    #1;
    check("mr_inp", inp0, 0);
    check("mr_bv", bv0, 0);
    check("mr_lb", lb0, 0);
    check("mr_busy", busy0, 0);
    check("mr_rdy", r0, 1);
    q0.delete();
    cyc(2);
    reset = 1'b1;
    cyc(1);
    send(0, 8'h81, 8'h81, 8, w1);
    idle(0);
    drain(0);
    check("mr_run", lastrun[0], 8);

    cyc(3);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
